// File: rtl/bus_arb_rr.sv
// Shared-bus arbiter: fixed-priority or round-robin grant with tenure limit.
// Optional transaction timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arb_rr #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MODE           = 1,
  parameter int unsigned MAX_TENURE     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         m_req_,
  output logic [NUM_MASTERS-1:0]         m_grnt_,
  input  logic                           s_as_,
  input  logic                           m_rdy_,
  output logic [$clog2(NUM_MASTERS)-1:0] grnt_id,
  output logic                           grnt_vld,
  output logic                           bus_err
);

  localparam int unsigned ID_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("bus_arb_rr: parameter out of range");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [7:0]             ten_cnt;
  logic [7:0]             ten_next;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] cand;
  logic                   in_flight;
  logic                   contended;
  logic                   released;
  logic                   ten_hit;
  logic                   to_hit;
  logic                   grnt_chg;
  logic                   win_found;
  logic [ID_W-1:0]        win_id;

  // First requester in policy order; round-robin starts just past the last owner.
  function automatic logic [ID_W:0] pick(input logic [NUM_MASTERS-1:0] c,
                                         input logic [ID_W-1:0] ptr);
    logic [ID_W:0] r;
    int unsigned   idx;
    r = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (MODE == 0) ? i : (32'(ptr) + 32'd1 + i) % NUM_MASTERS;
      if (!r[ID_W] && c[ID_W'(idx)]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  // m_grnt_ is high for every non-owner, so this masks out the current owner.
  assign req       = ~m_req_;
  assign cand      = req & m_grnt_;
  assign in_flight = ~s_as_ & m_rdy_;
  assign contended = (state == OWNED) && (|cand);
  assign released  = (state == OWNED) && m_req_[grnt_id];

  assign {win_found, win_id} = pick(cand, rr_ptr);

  always_comb begin
    ten_next = 8'd0;
    if (contended) ten_next = (ten_cnt == 8'hFF) ? ten_cnt : ten_cnt + 8'd1;
  end

  // Tenure expiry counts the current contended cycle; waits for the bus to go quiet.
  assign ten_hit  = (MAX_TENURE != 0) && contended && !in_flight &&
                    (32'(ten_next) >= MAX_TENURE);
  assign grnt_chg = (state == IDLE) ? win_found : (to_hit || ten_hit || released);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic [15:0] to_next;

  always_comb begin
    to_next = to_cnt;
    if (!m_rdy_)        to_next = 16'd0;
    else if (in_flight) to_next = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
  end

  assign to_hit = (state == OWNED) && in_flight && (32'(to_next) >= TIMEOUT_CYCLES);

  // Stall counter restarts with each new owner.
  always_ff @(posedge clk) begin
    if (reset || grnt_chg || state == IDLE) to_cnt <= 16'd0;
    else                                    to_cnt <= to_next;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Ownership FSM; timeout, tenure and release all collapse into one re-arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_grnt_  <= '1;
      grnt_id  <= '0;
      grnt_vld <= 1'b0;
      bus_err  <= 1'b0;
      ten_cnt  <= 8'd0;
      rr_ptr   <= ID_W'(NUM_MASTERS - 1);
    end else begin
      bus_err <= to_hit;
      if (grnt_chg) begin
        ten_cnt <= 8'd0;
        if (win_found) begin
          state    <= OWNED;
          m_grnt_  <= ~(NUM_MASTERS'(1) << win_id);
          grnt_id  <= win_id;
          grnt_vld <= 1'b1;
          rr_ptr   <= win_id;
        end else begin
          state    <= IDLE;
          m_grnt_  <= '1;
          grnt_id  <= '0;
          grnt_vld <= 1'b0;
        end
      end else begin
        ten_cnt <= (state == OWNED) ? ten_next : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_rr.sv
// Directed bench for bus_arb_rr: a round-robin instance and a fixed-priority instance.
module tb_bus_arb_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rr_req_, rr_grnt_, fp_req_, fp_grnt_;
  logic       rr_as_, rr_rdy_, fp_as_, fp_rdy_;
  logic [1:0] rr_id, fp_id;
  logic       rr_vld, fp_vld, rr_err, fp_err;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  bus_arb_rr #(.NUM_MASTERS(4), .MODE(1), .MAX_TENURE(4), .TIMEOUT_CYCLES(8)) u_rr (
    .clk(clk), .reset(reset), .m_req_(rr_req_), .m_grnt_(rr_grnt_), .s_as_(rr_as_),
    .m_rdy_(rr_rdy_), .grnt_id(rr_id), .grnt_vld(rr_vld), .bus_err(rr_err));

  bus_arb_rr #(.NUM_MASTERS(4), .MODE(0), .MAX_TENURE(0), .TIMEOUT_CYCLES(8)) u_fp (
    .clk(clk), .reset(reset), .m_req_(fp_req_), .m_grnt_(fp_grnt_), .s_as_(fp_as_),
    .m_rdy_(fp_rdy_), .grnt_id(fp_id), .grnt_vld(fp_vld), .bus_err(fp_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rr(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic vld);
    chk({tag, "_grnt"}, 8'(rr_grnt_), 8'(g));
    chk({tag, "_id"},   8'(rr_id),    8'(id));
    chk({tag, "_vld"},  8'(rr_vld),   8'(vld));
  endtask

  initial begin
    int unsigned order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  eg;

    reset = 1'b1;
    rr_req_ = 4'hF; rr_as_ = 1'b1; rr_rdy_ = 1'b1;
    fp_req_ = 4'hF; fp_as_ = 1'b1; fp_rdy_ = 1'b1;
    tick();
    chk_rr("reset", 4'b1111, 2'd0, 1'b0);
    chk("reset_err", 8'(rr_err), 8'd0);
    chk("reset_fp_grnt", 8'(fp_grnt_), 8'h0F);

    // Single request, then release.
    reset = 1'b0; rr_req_ = 4'b1110;
    tick();
    chk_rr("single", 4'b1110, 2'd0, 1'b1);
    rr_req_ = 4'b1111;
    tick();
    chk_rr("single_rel", 4'b1111, 2'd0, 1'b0);

    // Round-robin with everyone requesting; each owner holds two cycles.
    reset = 1'b1; tick();
    reset = 1'b0; rr_req_ = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      eg = ~(4'b0001 << order[k]);
      chk_rr($sformatf("rr_grant%0d", k), eg, 2'(order[k]), 1'b1);
      if (k == 4) break;
      tick();
      chk_rr($sformatf("rr_hold%0d", k), eg, 2'(order[k]), 1'b1);
      rr_req_[2'(order[k])] = 1'b1;
      tick();
      rr_req_ = 4'b0000;
    end

    // Tenure limit with an idle bus: handover on the 4th contended cycle.
    reset = 1'b1; tick();
    reset = 1'b0; rr_req_ = 4'b1110;
    tick();
    chk("ten_own0", 8'(rr_id), 8'd0);
    rr_req_ = 4'b1010;
    tick(); tick(); tick();
    chk("ten_3rd", 8'(rr_id), 8'd0);
    tick();
    chk_rr("ten_4th", 4'b1011, 2'd2, 1'b1);

    // Tenure expiry deferred by an in-flight transaction until m_rdy_ low.
    tick();
    rr_as_ = 1'b0;
    tick(); tick(); tick();
    chk("ten_inflight", 8'(rr_id), 8'd2);
    rr_rdy_ = 1'b0;
    tick();
    chk_rr("ten_complete", 4'b1110, 2'd0, 1'b1);
    rr_as_ = 1'b1; rr_rdy_ = 1'b1;

    // Hung transaction by master 1 with master 3 waiting.
    reset = 1'b1; tick();
    reset = 1'b0; rr_req_ = 4'b1101;
    tick();
    chk("to_own1", 8'(rr_id), 8'd1);
    rr_req_ = 4'b0101; rr_as_ = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("to_wait%0d_err", k), 8'(rr_err), 8'd0);
      chk($sformatf("to_wait%0d_id", k), 8'(rr_id), 8'd1);
    end
    tick();
`ifdef BUS_ARB_TIMEOUT_EN
    chk("to_hit_err", 8'(rr_err), 8'd1);
    chk_rr("to_hit", 4'b0111, 2'd3, 1'b1);
    tick();
    chk("to_pulse_end", 8'(rr_err), 8'd0);
`else
    chk("hung_err", 8'(rr_err), 8'd0);
    chk_rr("hung", 4'b1101, 2'd1, 1'b1);
`endif
    rr_as_ = 1'b1;

    // Reset mid-transaction drops the grant; master 0 wins afterwards.
    reset = 1'b1; tick();
    reset = 1'b0; rr_req_ = 4'b1011;
    tick();
    chk("rst_own2", 8'(rr_id), 8'd2);
    rr_as_ = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_rr("rst_mid", 4'b1111, 2'd0, 1'b0);
    chk("rst_mid_err", 8'(rr_err), 8'd0);
    reset = 1'b0; rr_req_ = 4'b0000; rr_as_ = 1'b1;
    tick();
    chk_rr("rst_after", 4'b1110, 2'd0, 1'b1);

    // Fixed priority: 0 and 3 requesting, then 1 and 2 join.
    fp_req_ = 4'b0110;
    tick();
    chk("fp_own0", 8'(fp_grnt_), 8'h0E);
    fp_req_ = 4'b0111;
    tick();
    chk("fp_own3", 8'(fp_grnt_), 8'h07);
    chk("fp_own3_id", 8'(fp_id), 8'd3);
    fp_req_ = 4'b0000;
    tick(); tick();
    chk("fp_hold3", 8'(fp_id), 8'd3);
    fp_req_ = 4'b1000;
    tick();
    chk("fp_back0", 8'(fp_id), 8'd0);
    fp_req_ = 4'b1001;
    tick();
    chk("fp_then1", 8'(fp_grnt_), 8'h0D);
    fp_req_ = 4'b1111;
    tick();
    chk("fp_idle", 8'(fp_vld), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
